dl_capture_engine: RTL and testbench
====================================

// Module: dl_capture_engine
// PURPOSE
//  Command-driven multi-channel delay-line capture engine; second-generation UART-side driver.
//  - Takes byte commands from the UART RX path and selects one of P_CH delay lines.
//  - Captures either a raw word or P_SAMPLES edge-position codes into a result buffer.
//  - Streams header + buffer to the UART TX path over a valid/accept handshake.
// PARAMETERS
//  P_DL_LEN   32  delay-line length in bits per channel (>=4)
//  P_CH       2   number of delay-line channels (1..16)
//  P_SAMPLES  8   edge samples per EDGE capture (>=1)
//  Derived: EW=$clog2(P_DL_LEN); BUF_W=roundup8(max(P_DL_LEN,P_SAMPLES*EW)); NB=BUF_W/8
// PORTS
//  i_clk       in   1             clock
//  i_rst       in   1             reset
//  i_valid     in   1             command byte strobe (single cycle)
//  i_data      in   8             command: [3:0] opcode, [7:4] argument
//  o_valid     out  1             TX byte valid
//  i_accept    in   1             TX byte accepted
//  o_data      out  8             TX byte
//  i_dl_valid  in   P_CH          per-channel sample strobe
//  i_dl        in   P_CH*P_DL_LEN channel c at [c*P_DL_LEN +: P_DL_LEN]
//  o_busy      out  1             high whenever state != IDLE
//  Interface: one clock; reset is synchronous and active-high.
// BEHAVIOUR
//  Reset: state=IDLE, o_valid=0, o_data=0, o_busy=0, buffer=0, ch=0, pol=0, cap_ok=0.
//  Opcodes; any opcode not listed is ignored:
//    0x1 UNLOAD, 0x2 RAW, 0x3 EDGE: honoured in IDLE only, ignored otherwise.
//    0x4 SET_CH: ch=arg; ignored if arg>=P_CH. 0x5 SET_MODE: pol=arg[0]. Both honoured in IDLE only.
//    0xF ABORT: honoured in any state.
//  FSM IDLE->RAW|EDGE|UNLOAD on accepted cmd; o_busy rises the cycle after the command.
//  RAW/EDGE entry: buffer cleared, cap_ok=0.
//  Sample strobe: i_dl_valid[ch] only; strobes on other channels are ignored.
//  RAW: first i_dl_valid[ch] -> buffer=zero-ext word, cap_ok=1, ->IDLE next cycle.
//  EDGE: each i_dl_valid[ch] -> buffer={buffer,code} (EW-bit left shift).
//    Counter: 0..P_SAMPLES-1. After P_SAMPLES strobes: cap_ok=1, ->IDLE.
//    First sample ends up most significant of the used bits.
//  Edge code: w = pol ? ~dl : dl.
//    k = highest bit, 0..P_DL_LEN-2, with w[k]=1 & w[k+1]=0; code = k+1.
//    No such k -> code=0.
//  UNLOAD: NB+1 bytes, header first, then buffer MSB-first.
//    Header = {cap_ok,pol,2'b00,ch[3:0]}.
//    o_valid rises the cycle after the command.
//    o_data stable while o_valid & !i_accept.
//    o_valid&i_accept: next byte next cycle, o_valid held.
//    After last byte: o_valid=0, ->IDLE. i_accept while !o_valid is ignored.
//    UNLOAD does not alter buffer or cap_ok, so UNLOAD can be repeated.
//  ABORT: ->IDLE next cycle, o_valid=0 (drops without accept), cap_ok=0, buffer kept.
//  Simultaneous events:
//    Cmd in the same cycle as the final capture strobe: ignored (state not yet IDLE).
//    ABORT + strobe: ABORT wins.
//  Reset mid-operation: immediate return to reset values on the next clock edge.
// STRUCTURE
//  dl_capture_pkg: opcode enum, state enum (IDLE,RAW,EDGE,UNLOAD), header packing function.
//  Sub-module dl_edge_encoder #(P_DL_LEN): combinational polarity-select + priority encoder -> EW-bit code.
//  Channel mux, buffer shift register, sample and byte counters all live in dl_capture_engine.
// TESTING (defaults; NB=5)
//  - 0x14, 0x02, ch1 dl=0xDEADBEEF, 0x01, accept=1 -> bytes 0x81,0x00,0xDE,0xAD,0xBE,0xEF; then o_busy=0.
//  - 0x03, 8 strobes ch0 dl=0x0000FFFF, 0x01 -> bytes 0x80,0x84,0x21,0x08,0x42,0x10.
//  - 0x15, 0x03, 8 strobes dl=0xFFFF0000 -> header 0xC0 and same 5 data bytes; dl=0xFFFFFFFF -> 0xC0, five 0x00.
//  - RAW capture then UNLOAD, accept low 5 cycles per byte -> o_valid held 1, o_data stable, 6 bytes total.
//  - 0x03, 3 strobes, 0x0F, 0x01 -> o_busy 0 the cycle after ABORT; header 0x00 (cap_ok=0).
//  - Edge cases:
//    - ch1 strobes during ch0 EDGE -> no progress.
//    - 0x24 with P_CH=2 -> ch unchanged.
//    - i_rst mid-UNLOAD -> o_valid=0 next edge, next header 0x00.

Source files
------------

// File: rtl/dl_capture_pkg.sv
// Shared types and helpers for the delay-line capture engine.
package dl_capture_pkg;

    typedef enum logic [3:0] {
        OP_UNLOAD   = 4'h1,
        OP_RAW      = 4'h2,
        OP_EDGE     = 4'h3,
        OP_SET_CH   = 4'h4,
        OP_SET_MODE = 4'h5,
        OP_ABORT    = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RAW,
        ST_EDGE,
        ST_UNLOAD
    } state_e;

    // Result buffer width: the larger of a raw word and a full edge record, rounded up to bytes.
    function automatic int unsigned buf_width(input int unsigned dl_len, input int unsigned samples);
        int unsigned ew;
        int unsigned w;
        ew = $clog2(dl_len);
        w  = (dl_len > samples * ew) ? dl_len : samples * ew;
        return ((w + 7) / 8) * 8;
    endfunction

    function automatic logic [7:0] pack_header(input logic cap_ok, input logic pol, input logic [3:0] ch);
        return {cap_ok, pol, 2'b00, ch};
    endfunction

endpackage

// File: rtl/dl_edge_encoder.sv
// Polarity-select and priority encoder: position (+1) of the highest 1->0 transition, 0 if none.
module dl_edge_encoder #(
    parameter int unsigned P_DL_LEN = 32
) (
    input  logic [P_DL_LEN-1:0]         dl,
    input  logic                        pol,
    output logic [$clog2(P_DL_LEN)-1:0] code_c
);

    localparam int unsigned EW = $clog2(P_DL_LEN);

    logic [P_DL_LEN-1:0] w;

    // Ascending scan so the highest matching position overwrites lower ones.
    always_comb begin
        w      = pol ? ~dl : dl;
        code_c = '0;
        for (int unsigned k = 0; k < P_DL_LEN - 1; k++) begin
            if (w[k] && !w[k+1]) begin
                code_c = EW'(k + 1);
            end
        end
    end

endmodule

// File: rtl/dl_capture_engine.sv
// Command-driven multi-channel delay-line capture engine with byte-stream unload.
module dl_capture_engine
    import dl_capture_pkg::*;
#(
    parameter int unsigned P_DL_LEN  = 32,
    parameter int unsigned P_CH      = 2,
    parameter int unsigned P_SAMPLES = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_valid,
    input  logic [7:0]                 i_data,
    output logic                       o_valid,
    input  logic                       i_accept,
    output logic [7:0]                 o_data,
    input  logic [P_CH-1:0]            i_dl_valid,
    input  logic [P_CH*P_DL_LEN-1:0]   i_dl,
    output logic                       o_busy
);

    localparam int unsigned EW     = $clog2(P_DL_LEN);
    localparam int unsigned BUF_W  = buf_width(P_DL_LEN, P_SAMPLES);
    localparam int unsigned NB     = BUF_W / 8;
    localparam int unsigned SCNT_W = (P_SAMPLES > 1) ? $clog2(P_SAMPLES) : 1;
    localparam int unsigned BC_W   = $clog2(NB + 1);

    state_e             state_q, state_d;
    logic [BUF_W-1:0]   buf_q, buf_d;
    logic               cap_ok_q, cap_ok_d;
    logic [3:0]         ch_q, ch_d;
    logic               pol_q, pol_d;
    logic [SCNT_W-1:0]  scnt_q, scnt_d;
    logic [BC_W-1:0]    bcnt_q, bcnt_d;
    logic               valid_d;
    logic [7:0]         data_d;
    logic               busy_d;

    logic [P_DL_LEN-1:0] sel_word;
    logic                sel_valid;
    logic [EW-1:0]       code_c;
    logic [3:0]          op;
    logic [3:0]          arg;

    // Channel mux: only the selected channel's strobe and word are visible.
    always_comb begin
        sel_word  = '0;
        sel_valid = 1'b0;
        for (int unsigned c = 0; c < P_CH; c++) begin
            if (ch_q == 4'(c)) begin
                sel_word  = i_dl[c*P_DL_LEN +: P_DL_LEN];
                sel_valid = i_dl_valid[c];
            end
        end
    end

    dl_edge_encoder #(
        .P_DL_LEN (P_DL_LEN)
    ) u_encoder (
        .dl     (sel_word),
        .pol    (pol_q),
        .code_c (code_c)
    );

    assign op  = i_data[3:0];
    assign arg = i_data[7:4];

    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        cap_ok_d = cap_ok_q;
        ch_d     = ch_q;
        pol_d    = pol_q;
        scnt_d   = scnt_q;
        bcnt_d   = bcnt_q;
        valid_d  = o_valid;
        data_d   = o_data;

        if (i_valid && op == OP_ABORT) begin
            // Abort wins over any simultaneous strobe or handshake; buffer is kept.
            state_d  = ST_IDLE;
            valid_d  = 1'b0;
            cap_ok_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_valid) begin
                        case (op)
                            OP_UNLOAD: begin
                                state_d = ST_UNLOAD;
                                bcnt_d  = '0;
                                valid_d = 1'b1;
                                data_d  = pack_header(cap_ok_q, pol_q, ch_q);
                            end
                            OP_RAW: begin
                                state_d  = ST_RAW;
                                buf_d    = '0;
                                cap_ok_d = 1'b0;
                            end
                            OP_EDGE: begin
                                state_d  = ST_EDGE;
                                buf_d    = '0;
                                cap_ok_d = 1'b0;
                                scnt_d   = '0;
                            end
                            OP_SET_CH: begin
                                if (32'(arg) < P_CH) begin
                                    ch_d = arg;
                                end
                            end
                            OP_SET_MODE: pol_d = arg[0];
                            default: ;
                        endcase
                    end
                end
                ST_RAW: begin
                    if (sel_valid) begin
                        buf_d    = BUF_W'(sel_word);
                        cap_ok_d = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
                ST_EDGE: begin
                    if (sel_valid) begin
                        buf_d = (buf_q << EW) | BUF_W'(code_c);
                        if (scnt_q == SCNT_W'(P_SAMPLES - 1)) begin
                            scnt_d   = '0;
                            cap_ok_d = 1'b1;
                            state_d  = ST_IDLE;
                        end else begin
                            scnt_d = scnt_q + SCNT_W'(1);
                        end
                    end
                end
                ST_UNLOAD: begin
                    // Byte index 0 is the header; 1..NB walk the buffer MSB-first.
                    if (o_valid && i_accept) begin
                        if (bcnt_q == BC_W'(NB)) begin
                            valid_d = 1'b0;
                            state_d = ST_IDLE;
                        end else begin
                            bcnt_d = bcnt_q + BC_W'(1);
                            data_d = 8'(buf_q >> (BUF_W - 8 * (32'(bcnt_q) + 1)));
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            buf_q    <= '0;
            cap_ok_q <= 1'b0;
            ch_q     <= '0;
            pol_q    <= 1'b0;
            scnt_q   <= '0;
            bcnt_q   <= '0;
            o_valid  <= 1'b0;
            o_data   <= '0;
            o_busy   <= 1'b0;
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            cap_ok_q <= cap_ok_d;
            ch_q     <= ch_d;
            pol_q    <= pol_d;
            scnt_q   <= scnt_d;
            bcnt_q   <= bcnt_d;
            o_valid  <= valid_d;
            o_data   <= data_d;
            o_busy   <= busy_d;
        end
    end

endmodule

// File: tb/tb_dl_capture_engine.sv
// Self-checking bench: directed literal cases plus randomized traffic against a behavioural model.
module tb_dl_capture_engine;

    localparam int unsigned DL = 32;
    localparam int unsigned CH = 2;
    localparam int unsigned NS = 8;
    localparam int unsigned EW = $clog2(DL);
    localparam int unsigned NB = (((DL > NS * EW) ? DL : NS * EW) + 7) / 8;

    logic               i_clk;
    logic               i_rst;
    logic               i_valid;
    logic [7:0]         i_data;
    logic               o_valid;
    logic               i_accept;
    logic [7:0]         o_data;
    logic [CH-1:0]      i_dl_valid;
    logic [CH*DL-1:0]   i_dl;
    logic               o_busy;

    dl_capture_engine #(
        .P_DL_LEN  (DL),
        .P_CH      (CH),
        .P_SAMPLES (NS)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .o_valid    (o_valid),
        .i_accept   (i_accept),
        .o_data     (o_data),
        .i_dl_valid (i_dl_valid),
        .i_dl       (i_dl),
        .o_busy     (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int                 m_mode;      // 0 idle, 1 raw, 2 edge, 3 unload
    bit                 m_capok;
    bit                 m_pol;
    int unsigned        m_ch;
    longint unsigned    m_buf;
    int unsigned        codes[$];
    logic [7:0]         tx_q[$];
    logic [7:0]         rx_q[$];
    bit                 chk_en;
    logic [3:0]         m_op;
    logic [3:0]         m_arg;
    bit                 m_strobe;
    logic [DL-1:0]      m_word;

    function automatic int unsigned edge_code(input logic [DL-1:0] dl, input bit pol);
        logic [DL-1:0] w;
        w = pol ? ~dl : dl;
        for (int k = DL - 2; k >= 0; k--) begin
            if (w[k] && !w[k+1]) return k + 1;
        end
        return 0;
    endfunction

    // Captured codes laid out with the first sample most significant.
    function automatic longint unsigned pack_codes();
        longint unsigned r;
        int n;
        r = 0;
        n = codes.size();
        for (int i = 0; i < n; i++) r = r + (longint'(codes[i]) << (EW * (n - 1 - i)));
        return r;
    endfunction

    always @(posedge i_clk) begin
        if (i_rst) begin
            m_mode = 0; m_capok = 0; m_pol = 0; m_ch = 0; m_buf = 0;
            codes.delete();
            tx_q.delete();
        end else begin
            m_op     = i_data[3:0];
            m_arg    = i_data[7:4];
            m_strobe = i_dl_valid[m_ch];
            m_word   = i_dl[m_ch*DL +: DL];
            if (i_valid && m_op == 4'hF) begin
                m_mode  = 0;
                m_capok = 0;
                tx_q.delete();
            end else begin
                case (m_mode)
                    0: if (i_valid) begin
                        case (m_op)
                            4'h1: begin
                                tx_q.delete();
                                tx_q.push_back(8'(m_capok * 128 + m_pol * 64 + m_ch));
                                for (int i = NB - 1; i >= 0; i--) tx_q.push_back(8'(m_buf >> (8 * i)));
                                m_mode = 3;
                            end
                            4'h2: begin m_mode = 1; m_buf = 0; m_capok = 0; end
                            4'h3: begin m_mode = 2; m_buf = 0; m_capok = 0; codes.delete(); end
                            4'h4: if (m_arg < CH) m_ch = m_arg;
                            4'h5: m_pol = m_arg[0];
                            default: ;
                        endcase
                    end
                    1: if (m_strobe) begin
                        m_buf = longint'(m_word); m_capok = 1; m_mode = 0;
                    end
                    2: if (m_strobe) begin
                        codes.push_back(edge_code(m_word, m_pol));
                        m_buf = pack_codes();
                        if (codes.size() == NS) begin m_capok = 1; m_mode = 0; end
                    end
                    3: if (i_accept) begin
                        void'(tx_q.pop_front());
                        if (tx_q.size() == 0) m_mode = 0;
                    end
                    default: m_mode = 0;
                endcase
            end
        end
    end

    // Per-cycle compare against the model, plus capture of handshaken bytes.
    always @(negedge i_clk) begin
        if (chk_en) begin
            check("busy", o_busy, (m_mode != 0));
            check("valid", o_valid, (tx_q.size() != 0));
            if (tx_q.size() != 0) check("data", o_data, tx_q[0]);
        end
        if (o_valid && i_accept) rx_q.push_back(o_data);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] b);
        i_valid = 1'b1;
        i_data  = b;
        tick();
        i_valid = 1'b0;
        i_data  = 8'h00;
    endtask

    task automatic strobe(input int c, input logic [DL-1:0] w);
        i_dl_valid    = '0;
        i_dl_valid[c] = 1'b1;
        i_dl[c*DL +: DL] = w;
        tick();
        i_dl_valid = '0;
    endtask

    task automatic unload(input int gap);
        int guard;
        rx_q.delete();
        send_cmd(8'h01);
        guard = 0;
        while (o_valid && guard < 400) begin
            i_accept = 1'b0;
            repeat (gap) tick();
            i_accept = 1'b1;
            tick();
            guard++;
        end
        i_accept = 1'b0;
        check("unload_done", o_valid, 0);
    endtask

    task automatic check_rx(input string nm, input logic [8*(NB+1)-1:0] exp);
        check({nm, "_len"}, rx_q.size(), NB + 1);
        for (int i = 0; i <= NB; i++) begin
            check(nm, (i < rx_q.size()) ? rx_q[i] : 9'h1FF, exp[8*(NB-i) +: 8]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        chk_en = 0;
        i_rst = 1'b1; i_valid = 1'b0; i_data = '0; i_accept = 1'b0;
        i_dl_valid = '0; i_dl = '0;
        repeat (3) tick();
        chk_en = 1;
        check("rst_valid", o_valid, 0);
        check("rst_data", o_data, 0);
        check("rst_busy", o_busy, 0);
        i_rst = 1'b0;
        tick();

        // RAW capture on channel 1
        send_cmd(8'h14);
        send_cmd(8'h02);
        strobe(1, 32'hDEADBEEF);
        unload(0);
        check_rx("raw_ch1", 48'h81_00DEADBEEF);
        check("busy_after_unload", o_busy, 0);

        // EDGE capture, polarity 0
        send_cmd(8'h04);
        send_cmd(8'h03);
        repeat (NS) strobe(0, 32'h0000FFFF);
        unload(0);
        check_rx("edge_pol0", 48'h80_8421084210);

        // EDGE capture, polarity 1
        send_cmd(8'h15);
        send_cmd(8'h03);
        repeat (NS) strobe(0, 32'hFFFF0000);
        unload(0);
        check_rx("edge_pol1", 48'hC0_8421084210);
        send_cmd(8'h03);
        repeat (NS) strobe(0, 32'hFFFFFFFF);
        unload(0);
        check_rx("edge_none", 48'hC0_0000000000);

        // RAW with slow consumer
        send_cmd(8'h05);
        send_cmd(8'h02);
        strobe(0, 32'h12345678);
        unload(5);
        check_rx("raw_slow", 48'h80_0012345678);

        // ABORT mid-EDGE keeps partial buffer, clears cap_ok
        send_cmd(8'h03);
        repeat (3) strobe(0, 32'h0000FFFF);
        send_cmd(8'h0F);
        check("abort_busy", o_busy, 0);
        unload(0);
        check_rx("abort_partial", 48'h00_0000004210);

        // Strobes on the unselected channel make no progress
        send_cmd(8'h03);
        repeat (10) strobe(1, 32'h0000FFFF);
        check("iso_busy", o_busy, 1);
        repeat (NS) strobe(0, 32'h000000FF);
        unload(0);
        check_rx("iso_edge", 48'h80_4210842108);

        // Out-of-range channel select is ignored
        send_cmd(8'h24);
        unload(0);
        check("set_ch_range", rx_q[0], 8'h80);

        // Reset in the middle of an unload
        send_cmd(8'h01);
        i_accept = 1'b0;
        tick();
        tick();
        i_rst = 1'b1;
        tick();
        check("rst_mid_valid", o_valid, 0);
        check("rst_mid_busy", o_busy, 0);
        i_rst = 1'b0;
        unload(0);
        check_rx("post_rst", 48'h00_0000000000);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            i_rst   = ($urandom_range(0, 599) == 0);
            i_valid = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 11))
                0, 1:  i_data = 8'h01;
                2:     i_data = 8'h02;
                3, 4:  i_data = 8'h03;
                5:     i_data = {4'($urandom_range(0, 3)), 4'h4};
                6:     i_data = {4'($urandom), 4'h5};
                7:     i_data = 8'h0F;
                default: i_data = 8'($urandom);
            endcase
            i_dl_valid = CH'($urandom);
            for (int c = 0; c < CH; c++) begin
                case ($urandom_range(0, 3))
                    0: i_dl[c*DL +: DL] = $urandom;
                    1: i_dl[c*DL +: DL] = '1;
                    2: i_dl[c*DL +: DL] = '0;
                    default: i_dl[c*DL +: DL] = $urandom >> $urandom_range(0, DL - 1);
                endcase
            end
            i_accept = ($urandom_range(0, 2) != 0);
            tick();
        end
        i_rst = 1'b0; i_valid = 1'b0; i_dl_valid = '0; i_accept = 1'b0;
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
